// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcode and FSM state enumerations shared by alu_seq
package alu_seq_pkg;

  localparam int OPCODE_W = 3;

  typedef enum logic [OPCODE_W-1:0] {
    OP_PASSA = 3'd0,
    OP_ADD   = 3'd1,
    OP_SUB   = 3'd2,
    OP_AND   = 3'd3,
    OP_XOR   = 3'd4,
    OP_ABS   = 3'd5,
    OP_MUL   = 3'd6,
    OP_PASSB = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_seq_mul.sv
// rtl/alu_seq_mul.sv - iterative signed shift-add multiplier, one partial product per cycle
module alu_seq_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] pp;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               busy;
  logic               last;

  // The multiplier MSB carries negative weight, so its partial product is subtracted.
  assign last = (cnt == CW'(WIDTH - 1));

  // Current partial product from the low multiplier bit.
  always_comb begin
    pp = '0;
    if (mplier[0]) begin
      pp = last ? -mcand : mcand;
    end
  end

  // The final partial product is folded in combinationally so done lands in the WIDTH-th busy cycle.
  assign done    = busy && last;
  assign product = acc + pp;

  // Operand load on start, then one accumulate/shift step per cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      mcand  <= {{WIDTH{a[WIDTH-1]}}, a};
      acc    <= '0;
      mplier <= b;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= acc + pp;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (last) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU with single-cycle ops and a multi-cycle signed multiply
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] accum,
  input  logic [WIDTH-1:0] data,
  input  logic [2:0]       opcode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             state;
  state_t             next_state;
  logic               accept;
  logic               is_mul;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic [WIDTH-1:0]   res;
  logic               res_c;
  logic               res_v;
  logic [WIDTH:0]     sum_ext;
  logic [WIDTH:0]     diff_ext;
  logic               mul_ovf;

  assign is_mul    = (op_t'(opcode) == OP_MUL);
  assign mul_start = accept && is_mul;
  assign mul_ovf   = (mul_product[2*WIDTH-1:WIDTH] != {WIDTH{mul_product[WIDTH-1]}});

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (accum),
    .b       (data),
    .done    (mul_done),
    .product (mul_product)
  );

  // Single-cycle result and flags for every opcode except MUL.
  always_comb begin
    res      = '0;
    res_c    = 1'b0;
    res_v    = 1'b0;
    sum_ext  = {1'b0, accum} + {1'b0, data};
    diff_ext = {1'b0, accum} - {1'b0, data};
    case (op_t'(opcode))
      OP_PASSA: res = accum;
      OP_ADD: begin
        res   = sum_ext[WIDTH-1:0];
        res_c = sum_ext[WIDTH];
        res_v = (accum[WIDTH-1] == data[WIDTH-1]) && (res[WIDTH-1] != accum[WIDTH-1]);
      end
      OP_SUB: begin
        res   = diff_ext[WIDTH-1:0];
        res_c = ~diff_ext[WIDTH];
        res_v = (accum[WIDTH-1] != data[WIDTH-1]) && (res[WIDTH-1] != accum[WIDTH-1]);
      end
      OP_AND: res = accum & data;
      OP_XOR: res = accum ^ data;
      OP_ABS: begin
        res   = accum[WIDTH-1] ? -accum : accum;
        res_v = (accum == MIN_NEG);
      end
      OP_PASSB: res = data;
      default: res = '0;
    endcase
  end

  // Handshake decode and next-state selection.
  always_comb begin
    next_state = state;
    in_ready   = (state == IDLE);
    out_valid  = (state == DONE);
    accept     = in_valid && (state == IDLE);
    case (state)
      IDLE: if (accept) next_state = is_mul ? BUSY : DONE;
      BUSY: if (mul_done) next_state = DONE;
      DONE: if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Result and flag registers, loaded on accept or at multiply completion and held otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_out <= '0;
      zero    <= 1'b0;
      neg     <= 1'b0;
      carry   <= 1'b0;
      ovf     <= 1'b0;
    end else if (accept && !is_mul) begin
      alu_out <= res;
      zero    <= (res == '0);
      neg     <= res[WIDTH-1];
      carry   <= res_c;
      ovf     <= res_v;
    end else if (state == BUSY && mul_done) begin
      alu_out <= mul_product[WIDTH-1:0];
      zero    <= (mul_product[WIDTH-1:0] == '0);
      neg     <= mul_product[WIDTH-1];
      carry   <= 1'b0;
      ovf     <= mul_ovf;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] accum;
  logic [W-1:0] data;
  logic [2:0]   opcode;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] alu_out;
  logic         out_valid;
  logic         out_ready;
  logic         zero;
  logic         neg;
  logic         carry;
  logic         ovf;

  int tests = 0;
  int fails = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .accum     (accum),
    .data      (data),
    .opcode    (opcode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_out   (alu_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .zero      (zero),
    .neg       (neg),
    .carry     (carry),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [11:0]  exp;
    int           lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [11:0] snap();
    return {alu_out, zero, neg, carry, ovf};
  endfunction

  // Reference: plain integer arithmetic, packed as {result, zero, neg, carry, ovf}.
  function automatic logic [11:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int ua, ub, sa, sb, r, sr;
    bit c, v;
    logic [W-1:0] res;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    c = 0;
    v = 0;
    r = 0;
    case (op)
      3'd0: r = ua;
      3'd1: begin r = ua + ub; c = (r > 255); sr = sa + sb; v = (sr > 127) || (sr < -128); end
      3'd2: begin r = ua - ub; c = (ua >= ub); sr = sa - sb; v = (sr > 127) || (sr < -128); end
      3'd3: r = ua & ub;
      3'd4: r = ua ^ ub;
      3'd5: begin r = (sa < 0) ? -sa : sa; v = (r == 128); end
      3'd6: begin r = sa * sb; v = (r > 127) || (r < -128); end
      default: r = ub;
    endcase
    res = r[W-1:0];
    return {res, (res == 0), res[W-1], c, v};
  endfunction

  // Issue one op from IDLE, scramble operands after accept, wait for the result, then retire it.
  task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [11:0] got, output int lat);
    accum    = a;
    data     = b;
    opcode   = op;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    accum    = W'($urandom);
    data     = W'($urandom);
    opcode   = 3'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    got = snap();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [11:0] got;
    logic [11:0] exp;
    int          lat;
    int          cnt;
    logic        seen;
    logic [2:0]  op;
    logic [W-1:0] a, b;

    vecs.push_back('{OP_ADD,   8'h7F, 8'h01, {8'h80, 4'b0101}, 1});
    vecs.push_back('{OP_SUB,   8'h05, 8'h05, {8'h00, 4'b1010}, 1});
    vecs.push_back('{OP_SUB,   8'h03, 8'h05, {8'hFE, 4'b0100}, 1});
    vecs.push_back('{OP_ABS,   8'hFB, 8'h00, {8'h05, 4'b0000}, 1});
    vecs.push_back('{OP_ABS,   8'h80, 8'h00, {8'h80, 4'b0101}, 1});
    vecs.push_back('{OP_MUL,   8'hFD, 8'h07, {8'hEB, 4'b0100}, 9});
    vecs.push_back('{OP_MUL,   8'h10, 8'h10, {8'h00, 4'b1001}, 9});
    vecs.push_back('{OP_PASSA, 8'hA5, 8'h11, {8'hA5, 4'b0100}, 1});
    vecs.push_back('{OP_PASSB, 8'h11, 8'h3C, {8'h3C, 4'b0000}, 1});
    vecs.push_back('{OP_AND,   8'hF0, 8'h3C, {8'h30, 4'b0000}, 1});
    vecs.push_back('{OP_XOR,   8'hFF, 8'h0F, {8'hF0, 4'b0100}, 1});
    vecs.push_back('{OP_ADD,   8'hFF, 8'h01, {8'h00, 4'b1010}, 1});
    vecs.push_back('{OP_SUB,   8'h80, 8'h01, {8'h7F, 4'b0011}, 1});
    vecs.push_back('{OP_MUL,   8'h7F, 8'h7F, {8'h01, 4'b0001}, 9});
    vecs.push_back('{OP_MUL,   8'hFF, 8'hFF, {8'h01, 4'b0000}, 9});

    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    accum     = '0;
    data      = '0;
    opcode    = '0;
    #3;
    check("reset_state", {in_ready, out_valid, snap()}, {1'b1, 1'b0, 12'h000});
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Directed table; the first entry is accepted on the first edge after reset release.
    foreach (vecs[i]) begin
      check($sformatf("vec%0d_ready", i), in_ready, 1'b1);
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, got, lat);
      check($sformatf("vec%0d_result", i), got, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
    end

    // Randomized ops against the reference model.
    for (int i = 0; i < 150; i++) begin
      op = 3'($urandom);
      a  = W'($urandom);
      b  = W'($urandom);
      if (i % 10 == 0) a = 8'h80;
      do_op(op, a, b, got, lat);
      check($sformatf("rand%0d_op%0d_%0h_%0h", i, op, a, b), got, model(op, a, b));
      check($sformatf("rand%0d_latency", i), lat, (op == 3'd6) ? 9 : 1);
    end

    // Backpressure: result holds and in_valid is dropped while out_ready is low.
    out_ready = 1'b0;
    accum     = 8'h7F;
    data      = 8'h01;
    opcode    = OP_ADD;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    exp = model(3'd1, 8'h7F, 8'h01);
    check("bp_first", {out_valid, snap()}, {1'b1, exp});
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      opcode   = OP_PASSB;
      data     = W'($urandom);
      @(posedge clk);
      #1;
      check($sformatf("bp_hold%0d", k), {out_valid, in_ready, snap()}, {1'b1, 1'b0, exp});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release", {out_valid, in_ready}, 2'b01);
    @(posedge clk);
    #1;
    check("bp_no_queue", {out_valid, in_ready, snap()}, {1'b0, 1'b1, exp});

    // Throughput: in_valid held high with out_ready high gives one result every 2 cycles.
    accum    = 8'h12;
    data     = 8'h34;
    opcode   = OP_ADD;
    in_valid = 1'b1;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) cnt++;
    end
    in_valid = 1'b0;
    check("throughput", cnt, 10);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;

    // Reset in the third BUSY cycle of a multiply.
    accum    = 8'hFD;
    data     = 8'h07;
    opcode   = OP_MUL;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("mul_busy_ready", {out_valid, in_ready}, 2'b00);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("midmul_reset", {out_valid, in_ready, snap()}, {1'b0, 1'b1, 12'h000});
    #2;
    reset = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk);
      #1;
      seen |= out_valid;
    end
    check("midmul_no_result", seen, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
